sdpram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences one distributed simple-dual-port RAM instance (ADDR_WIDTH addr, 2**ADDR_WIDTH words) as a synchronous FIFO.
- Owns the write/read pointers and drives the RAM write-enable and both address buses.
- Generates full/empty/almost flags, fill level, read-valid strobe and error pulses.
- The RAM data path (wr_data/rd_data) is wired directly between the user and the RAM; this block never touches data.
- Used by the matrix datapath wherever a same-clock FIFO is needed.

---
 rtl/sdpram_fifo_ctrl_if.sv | 37 +++
 rtl/sdpram_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_sdpram_fifo_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdpram_fifo_ctrl_if.sv
// rtl/sdpram_fifo_ctrl_if.sv - user request / RAM control / status bundle for sdpram_fifo_ctrl
interface sdpram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4
) ();
  // user requests
  logic                  wr_en;
  logic                  rd_en;
  // RAM control
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  // status
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  rd_valid;
  logic                  wr_err;
  logic                  rd_err;

  // user side: issues requests, observes RAM control and status
  modport master (
    output wr_en, rd_en,
    input  ram_wr_en, ram_wr_addr, ram_rd_addr,
    input  full, empty, almost_full, almost_empty, level,
    input  rd_valid, wr_err, rd_err
  );

  // controller side
  modport slave (
    input  wr_en, rd_en,
    output ram_wr_en, ram_wr_addr, ram_rd_addr,
    output full, empty, almost_full, almost_empty, level,
    output rd_valid, wr_err, rd_err
  );
endinterface

// File: rtl/sdpram_fifo_ctrl.sv
// rtl/sdpram_fifo_ctrl.sv - pointer and flag sequencer running a simple-dual-port RAM as a FIFO
module sdpram_fifo_ctrl #(
  parameter int ADDR_WIDTH       = 4,
  parameter int ALMOST_FULL_NUM  = 14,
  parameter int ALMOST_EMPTY_NUM = 2,
  parameter int OUT_REG          = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  sdpram_fifo_ctrl_if.slave fifo
);
  localparam int            PW      = ADDR_WIDTH + 1;
  localparam int            DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_L    = PW'(ALMOST_EMPTY_NUM);
  localparam logic [PW-1:0] ONE_L   = PW'(1);

  // Pointers carry one extra wrap bit; only the low bits address the RAM.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level_q;

  logic full_w;
  logic empty_w;
  logic wr_fire;
  logic rd_fire;
  logic wr_err_q;
  logic rd_err_q;

  // Flags come straight off the level register, so they reflect state
  // after the accepting edge with no extra pipeline stage.
  assign full_w  = (level_q == DEPTH_L);
  assign empty_w = (level_q == '0);

  // Acceptance uses the registered flags only: a read in the same cycle
  // does not make room for a write at full, and vice versa at empty.
  assign wr_fire = fifo.wr_en & ~full_w  & ~clr;
  assign rd_fire = fifo.rd_en & ~empty_w & ~clr;

  assign fifo.ram_wr_en    = wr_fire;
  assign fifo.ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
  assign fifo.ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
  assign fifo.full         = full_w;
  assign fifo.empty        = empty_w;
  assign fifo.almost_full  = (level_q >= AF_L);
  assign fifo.almost_empty = (level_q <= AE_L);
  assign fifo.level        = level_q;
  assign fifo.wr_err       = wr_err_q;
  assign fifo.rd_err       = rd_err_q;

  // Write pointer: advances on every accepted write, flushed by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + ONE_L;
    end
  end

  // Read pointer: advances on every accepted read, flushed by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
    end else if (rd_fire) begin
      rd_ptr <= rd_ptr + ONE_L;
    end
  end

  // Fill level kept as its own register so the flags decode from a flop
  // instead of a pointer subtractor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (clr) begin
      level_q <= '0;
    end else begin
      unique case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

  // Rejected-request pulses, one cycle per refused request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= fifo.wr_en & full_w  & ~clr;
      rd_err_q <= fifo.rd_en & empty_w & ~clr;
    end
  end

  // rd_valid follows the RAM read latency: same cycle for a show-ahead
  // RAM, one cycle later when the RAM registers its output.
  if (OUT_REG != 0) begin : g_rd_valid_reg
    logic rd_valid_q;

    // Registered read strobe lines up with the RAM's q_reg.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_fire;
      end
    end

    assign fifo.rd_valid = rd_valid_q;
  end else begin : g_rd_valid_comb
    assign fifo.rd_valid = rd_fire;
  end

  // Threshold parameters outside their legal range.
  a_almost_full_range : assert property (@(posedge clk)
    (ALMOST_FULL_NUM >= 1) && (ALMOST_FULL_NUM <= DEPTH))
    else $error("sdpram_fifo_ctrl: ALMOST_FULL_NUM=%0d outside 1..%0d", ALMOST_FULL_NUM, DEPTH);

  a_almost_empty_range : assert property (@(posedge clk)
    (ALMOST_EMPTY_NUM >= 0) && (ALMOST_EMPTY_NUM <= DEPTH - 1))
    else $error("sdpram_fifo_ctrl: ALMOST_EMPTY_NUM=%0d outside 0..%0d", ALMOST_EMPTY_NUM, DEPTH - 1);

  // The level register must never drift from the pointer difference.
  a_level_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    level_q == PW'(wr_ptr - rd_ptr))
    else $error("sdpram_fifo_ctrl: level %0d disagrees with pointers %0d/%0d", level_q, wr_ptr, rd_ptr);

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb/tb_sdpram_fifo_ctrl.sv - scoreboard bench for sdpram_fifo_ctrl with show-ahead and registered RAM models
module tb_sdpram_fifo_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl_if #(.ADDR_WIDTH(AW)) if0 ();
  sdpram_fifo_ctrl_if #(.ADDR_WIDTH(AW)) if1 ();

  assign if0.wr_en = wr_en;
  assign if0.rd_en = rd_en;
  assign if1.wr_en = wr_en;
  assign if1.rd_en = rd_en;

  sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .fifo(if0.slave));
  sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .fifo(if1.slave));

  // RAM models: show-ahead for instance 0, output-registered for instance 1
  logic [7:0] mem0 [DEPTH];
  logic [7:0] mem1 [DEPTH];
  logic [7:0] q1;
  logic [7:0] rd_data0;
  logic [7:0] rd_data1;

  always @(posedge clk) begin
    if (if0.ram_wr_en) mem0[if0.ram_wr_addr] <= wr_data;
    if (if1.ram_wr_en) mem1[if1.ram_wr_addr] <= wr_data;
    q1 <= mem1[if1.ram_rd_addr];
  end
  assign rd_data0 = mem0[if0.ram_rd_addr];
  assign rd_data1 = q1;

  int errs = 0;
  int checks = 0;

  // reference model and scoreboards
  logic [7:0] mq [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic       exp_wr_err = 1'b0;
  logic       exp_rd_err = 1'b0;

  // pre-edge snapshots of combinational outputs
  logic       s_we0, s_we1, s_rv0, s_af0;
  logic [3:0] s_wa, s_ra;
  logic [7:0] s_rd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [4:0] lev, input logic f, input logic e,
                            input logic af, input logic ae, input logic we, input logic re);
    int n;
    n = mq.size();
    chk({tag, "_level"}, lev, n);
    chk({tag, "_full"}, f, n == DEPTH);
    chk({tag, "_empty"}, e, n == 0);
    chk({tag, "_afull"}, af, n >= 14);
    chk({tag, "_aempty"}, ae, n <= 2);
    chk({tag, "_wr_err"}, we, exp_wr_err);
    chk({tag, "_rd_err"}, re, exp_rd_err);
  endtask

  // monitor: status against the model and read data against the scoreboards
  always @(negedge clk) begin
    if (rst_n) begin
      chk_status("m0", if0.level, if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.wr_err, if0.rd_err);
      chk_status("m1", if1.level, if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.wr_err, if1.rd_err);
      if (if0.rd_valid) begin
        chk("m0_rv_expected", exp0.size() != 0, 1);
        if (exp0.size() != 0) chk("m0_data", rd_data0, exp0.pop_front());
      end
      if (if1.rd_valid) begin
        chk("m1_rv_expected", exp1.size() != 0, 1);
        if (exp1.size() != 0) chk("m1_data", rd_data1, exp1.pop_front());
      end
    end
  end

  // one clock of stimulus; returns 1 time unit after the edge
  task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
    int  lvl;
    bit  wf, rf;
    wr_en   = w;
    rd_en   = r;
    clr     = c;
    wr_data = d;
    lvl = mq.size();
    wf  = w && !c && (lvl < DEPTH);
    rf  = r && !c && (lvl > 0);
    if (rf) begin
      exp0.push_back(mq[0]);
      exp1.push_back(mq[0]);
    end
    @(negedge clk);
    s_we0 = if0.ram_wr_en;
    s_we1 = if1.ram_wr_en;
    s_wa  = if0.ram_wr_addr;
    s_ra  = if0.ram_rd_addr;
    s_rv0 = if0.rd_valid;
    s_rd0 = rd_data0;
    s_af0 = if0.almost_full;
    @(posedge clk);
    if (c) begin
      mq.delete();
    end else begin
      if (rf) void'(mq.pop_front());
      if (wf) mq.push_back(d);
    end
    exp_wr_err = w && !c && (lvl == DEPTH);
    exp_rd_err = r && !c && (lvl == 0);
    #1;
  endtask

  task automatic model_flush();
    mq.delete();
    exp0.delete();
    exp1.delete();
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    do_reset();
    chk("rst_empty", if0.empty, 1);
    chk("rst_full", if0.full, 0);
    chk("rst_aempty", if0.almost_empty, 1);
    chk("rst_afull", if0.almost_full, 0);
    chk("rst_level", if0.level, 0);
    chk("rst_ram_wr_en", if0.ram_wr_en, 0);
    chk("rst_wr_addr", if0.ram_wr_addr, 0);
    chk("rst_rd_addr", if0.ram_rd_addr, 0);
    chk("rst_rd_valid0", if0.rd_valid, 0);
    chk("rst_rd_valid1", if1.rd_valid, 0);

    // ---- 1: fill 16, then overflow attempt
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i));
      chk("t1_wr_addr", s_wa, i);
      chk("t1_ram_wr_en", s_we0, 1);
      chk("t1_full", if0.full, i == 15);
    end
    chk("t1_level16", if0.level, 16);
    cyc(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("t1_ovf_ram_wr_en", s_we0, 0);
    chk("t1_ovf_wr_err", if0.wr_err, 1);
    chk("t1_ovf_level", if0.level, 16);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1_wr_err_pulse", if0.wr_err, 0);

    // ---- 2: drain 16 on both read timings, then underflow attempt
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t2_rv0", s_rv0, 1);
      chk("t2_data0", s_rd0, i);
      chk("t2_rv1", if1.rd_valid, 1);
      chk("t2_data1", rd_data1, i);
    end
    chk("t2_empty", if0.empty, 1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t2_udf_rv0", s_rv0, 0);
    chk("t2_udf_rd_err", if0.rd_err, 1);
    chk("t2_udf_rd_addr", if0.ram_rd_addr, 0);
    chk("t2_udf_rv1", if1.rd_valid, 0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t2_rd_err_pulse", if0.rd_err, 0);

    // ---- 3: wrap-around
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t3_data_a", s_rd0, 8'h20 + i);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      if (i == 5) chk("t3_addr15", s_wa, 15);
      if (i == 6) chk("t3_addr_wrap", s_wa, 0);
      chk("t3_no_full", if0.full, 0);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t3_data_b", s_rd0, 8'h40 + i);
    end

    // ---- 4: simultaneous read and write
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
      chk("t4_level5", if0.level, 5);
    end
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
    chk("t4_full", if0.full, 1);
    cyc(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("t4_full_both_level", if0.level, 15);
    chk("t4_full_both_wr_err", if0.wr_err, 1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t4_empty", if0.empty, 1);
    cyc(1'b1, 1'b1, 1'b0, 8'h88);
    chk("t4_empty_both_rv0", s_rv0, 0);
    chk("t4_empty_both_level", if0.level, 1);
    chk("t4_empty_both_rd_err", if0.rd_err, 1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t4_last_data", s_rd0, 8'h88);

    // ---- 5: almost flags
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
    chk("t5_afull_13", if0.almost_full, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h0D);
    chk("t5_afull_pre_edge", s_af0, 0);
    chk("t5_afull_14", if0.almost_full, 1);
    chk("t5_afull_14_r", if1.almost_full, 1);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t5_level3", if0.level, 3);
    chk("t5_aempty_3", if0.almost_empty, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t5_aempty_2", if0.almost_empty, 1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // ---- 6: async reset mid-burst, then clr
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
    wr_en   = 1'b1;
    wr_data = 8'h99;
    #2;
    rst_n = 1'b0;
    model_flush();
    #1;
    chk("t6_rst_empty", if0.empty, 1);
    chk("t6_rst_level", if0.level, 0);
    chk("t6_rst_wr_addr", if0.ram_wr_addr, 0);
    chk("t6_rst_rd_addr", if0.ram_rd_addr, 0);
    chk("t6_rst_level_r", if1.level, 0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'hA0);
    chk("t6_post_rst_addr", s_wa, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_post_rst_data", s_rd0, 8'hA0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
    chk("t6_level9", if0.level, 9);
    cyc(1'b1, 1'b0, 1'b1, 8'hBB);
    chk("t6_clr_ram_wr_en", s_we0, 0);
    chk("t6_clr_ram_wr_en_r", s_we1, 0);
    chk("t6_clr_empty", if0.empty, 1);
    chk("t6_clr_level", if0.level, 0);
    chk("t6_clr_wr_addr", if0.ram_wr_addr, 0);
    chk("t6_clr_rd_addr", if0.ram_rd_addr, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'hC0);
    chk("t6_post_clr_addr", s_wa, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_post_clr_data", s_rd0, 8'hC0);

    // ---- drain scoreboards
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("sb0_drained", exp0.size(), 0);
    chk("sb1_drained", exp1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
